// File: rtl/cpu_types_pkg.sv
// Shared types and constants for the memory arbiter slice.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      I_ACC = 2'd1,
      D_ACC = 2'd2
   } arb_state_t;

   localparam word_t ARB_ERR_WORD = 32'hBAD1BAD1;

   // Timeout counter width: wide enough for the limit, never narrower than 8 bits.
   function automatic int tmo_width(input int timeout);
      int w;
      w = $clog2(timeout + 1);
      return (w < 8) ? 8 : w;
   endfunction

endpackage

// File: rtl/arb_streak_counter.sv
// Saturating count of consecutive data grants made while a fetch is waiting.
module arb_streak_counter #(
   parameter int MAX = 4
) (
   input  logic CLK,
   input  logic RST,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_sat
);

   localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);
   localparam logic [W-1:0] MAX_C = W'(MAX);

   logic [W-1:0] r_count;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != MAX_C)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_sat = (r_count == MAX_C);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between fetch and data requesters; data has priority
// with a bounded fetch starvation window, fetches stop after halt.
//   state | meaning
//   IDLE  | no access in flight, arbitrate this cycle
//   I_ACC | fetch access on the RAM port
//   D_ACC | data read/write access on the RAM port
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int DSTREAK = 4,
   parameter int TIMEOUT = 255
) (
   input  logic  CLK,
   input  logic  RST,
   input  logic  halt,
   input  logic  iREN,
   input  word_t iaddr,
   output word_t iload,
   output logic  iwait,
   input  logic  dREN,
   input  logic  dWEN,
   input  word_t daddr,
   input  word_t dstore,
   output word_t dload,
   output logic  dwait,
   output logic  ram_ren,
   output logic  ram_wen,
   output word_t ram_addr,
   output word_t ram_store,
   input  word_t ram_load,
   input  logic  ram_ready,
   output logic  ram_err
);

   localparam int TW = tmo_width(TIMEOUT);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   arb_state_t    r_state;
   logic          r_ren, r_wen, r_halt_q, r_err;
   word_t         r_addr, r_store;
   logic [TW-1:0] r_tmo;

   logic w_in_acc, w_ready, w_tmo_hit, w_done, w_dreq;
   logic w_streak_sat, w_force_i, w_grant_d, w_grant_i;

   assign w_in_acc  = (r_state != IDLE);
   // A reset cycle never signals completion, even if the RAM answers in it.
   assign w_ready   = w_in_acc & ram_ready & ~RST;
   assign w_tmo_hit = w_in_acc & ~ram_ready & ~RST & (r_tmo == TMO_LAST);
   assign w_done    = w_ready | w_tmo_hit;
   assign w_dreq    = dREN | dWEN;

   assign w_force_i = w_streak_sat & iREN & ~r_halt_q;
   assign w_grant_d = (r_state == IDLE) & w_dreq & ~w_force_i;
   assign w_grant_i = (r_state == IDLE) & ~w_grant_d & iREN & ~r_halt_q;

   arb_streak_counter #(.MAX(DSTREAK)) u_streak (
      .CLK   (CLK),
      .RST   (RST),
      .i_clr (~iREN | w_grant_i),
      .i_inc (w_grant_d & iREN),
      .o_sat (w_streak_sat)
   );

   assign iwait = iREN   & ~((r_state == I_ACC) & w_done);
   assign dwait = w_dreq & ~((r_state == D_ACC) & w_done);
   assign iload = w_tmo_hit ? ARB_ERR_WORD : ram_load;
   assign dload = w_tmo_hit ? ARB_ERR_WORD : ram_load;

   assign ram_ren   = r_ren;
   assign ram_wen   = r_wen;
   assign ram_addr  = r_addr;
   assign ram_store = r_store;
   assign ram_err   = r_err;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state  <= IDLE;
         r_ren    <= 1'b0;
         r_wen    <= 1'b0;
         r_addr   <= '0;
         r_store  <= '0;
         r_tmo    <= '0;
         r_halt_q <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_halt_q <= r_halt_q | halt;
         case (r_state)
            IDLE: begin
               r_tmo <= '0;
               if (w_grant_d) begin
                  r_state <= D_ACC;
                  r_addr  <= daddr;
                  r_store <= dstore;
                  r_ren   <= ~dWEN;
                  r_wen   <= dWEN;
               end else if (w_grant_i) begin
                  r_state <= I_ACC;
                  r_addr  <= iaddr;
                  r_ren   <= 1'b1;
                  r_wen   <= 1'b0;
               end
            end
            I_ACC, D_ACC: begin
               if (w_done) begin
                  r_state <= IDLE;
                  r_ren   <= 1'b0;
                  r_wen   <= 1'b0;
                  r_err   <= r_err | w_tmo_hit;
               end else begin
                  r_tmo <= r_tmo + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_ren   <= 1'b0;
               r_wen   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model, directed scenarios
// with literal expectations, then randomized traffic checked every cycle.
module tb_mem_arbiter;
   import cpu_types_pkg::*;

   localparam int DSTREAK = 4;
   localparam int TIMEOUT = 8;
   localparam logic [31:0] ERR_WORD = 32'hBAD1BAD1;

   logic        CLK = 1'b0;
   logic        RST, halt, iREN, dREN, dWEN, ram_ready;
   logic [31:0] iaddr, daddr, dstore, ram_load;
   logic [31:0] iload, dload, ram_addr, ram_store;
   logic        iwait, dwait, ram_ren, ram_wen, ram_err;

   int n_chk = 0;
   int n_err = 0;
   bit cmp_en = 0;

   // reference model: which requester owns the port (0 none, 1 fetch, 2 data)
   int          m_acc = 0;
   int          m_age = 0;
   int          m_streak = 0;
   bit          m_write = 0, m_halt = 0, m_err = 0, m_done_i = 0, m_done_d = 0;
   logic [31:0] m_addr = '0, m_store = '0;

   int n, ng, done_k;
   int g[8];
   int exp_g[8] = '{1, 1, 1, 1, 2, 1, 1, 1};
   bit prev;

   mem_arbiter #(.DSTREAK(DSTREAK), .TIMEOUT(TIMEOUT)) dut (
      .CLK(CLK), .RST(RST), .halt(halt),
      .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dload(dload), .dwait(dwait),
      .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
      .ram_store(ram_store), .ram_load(ram_load), .ram_ready(ram_ready),
      .ram_err(ram_err)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit f_rdy();
      return (m_acc != 0) && ram_ready && !RST;
   endfunction

   function automatic bit f_tmo();
      return (m_acc != 0) && !ram_ready && !RST && (m_age == TIMEOUT - 1);
   endfunction

   task automatic model_step();
      bit done, tmo, gi, gd, forced;
      m_done_i = 0;
      m_done_d = 0;
      if (RST) begin
         m_acc = 0; m_age = 0; m_streak = 0; m_write = 0;
         m_halt = 0; m_err = 0; m_addr = '0; m_store = '0;
         return;
      end
      done = f_rdy() || f_tmo();
      tmo  = f_tmo();
      gi = 0;
      gd = 0;
      if (m_acc != 0) begin
         if (done) begin
            if (tmo) m_err = 1;
            m_done_i = (m_acc == 1) && iREN;
            m_done_d = (m_acc == 2) && (dREN || dWEN);
            m_acc = 0;
         end else begin
            m_age++;
         end
      end else begin
         forced = (m_streak == DSTREAK) && iREN && !m_halt;
         if ((dREN || dWEN) && !forced) begin
            gd = 1; m_acc = 2; m_addr = daddr; m_store = dstore; m_write = dWEN; m_age = 0;
         end else if (iREN && !m_halt) begin
            gi = 1; m_acc = 1; m_addr = iaddr; m_write = 0; m_age = 0;
         end
      end
      if (!iREN || gi) m_streak = 0;
      else if (gd && m_streak < DSTREAK) m_streak++;
      if (halt) m_halt = 1;
   endtask

   // every-cycle comparison against the model, away from the active edge
   always @(negedge CLK) begin
      bit ew_i, ew_d, rdy, tmo;
      if (cmp_en) begin
         rdy  = f_rdy();
         tmo  = f_tmo();
         ew_i = iREN && !(m_acc == 1 && (rdy || tmo));
         ew_d = (dREN || dWEN) && !(m_acc == 2 && (rdy || tmo));
         chk("iwait", iwait, ew_i);
         chk("dwait", dwait, ew_d);
         chk("ram_ren", ram_ren, (m_acc == 1) || (m_acc == 2 && !m_write));
         chk("ram_wen", ram_wen, m_acc == 2 && m_write);
         chk("ram_addr", ram_addr, m_addr);
         chk("ram_store", ram_store, m_store);
         chk("ram_err", ram_err, m_err);
         if (iREN && !ew_i) chk("iload", iload, tmo ? ERR_WORD : ram_load);
         if ((dREN || dWEN) && !ew_d) chk("dload", dload, tmo ? ERR_WORD : ram_load);
      end
   end

   task automatic tick();
      @(posedge CLK);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      RST = 1; halt = 0; iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0;
      tick();
      RST = 0;
      #3;
      chk("rst_ram_ren", ram_ren, 0);
      chk("rst_ram_wen", ram_wen, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ram_store", ram_store, 0);
      chk("rst_ram_err", ram_err, 0);
      chk("rst_iwait", iwait, 0);
      chk("rst_dwait", dwait, 0);
   endtask

   task automatic rand_cycle(input int p_rdy, input bit allow_halt);
      tick();
      RST  = ($urandom_range(0, 299) == 0);
      halt = allow_halt && ($urandom_range(0, 199) == 0);
      if (iREN && (m_done_i || $urandom_range(0, 40) == 0)) iREN = 0;
      else if (!iREN && $urandom_range(0, 2) == 0) begin
         iREN = 1; iaddr = $urandom;
      end
      if ((dREN || dWEN) && (m_done_d || $urandom_range(0, 40) == 0)) begin
         dREN = 0; dWEN = 0;
      end else if (!(dREN || dWEN) && $urandom_range(0, 2) == 0) begin
         case ($urandom_range(0, 2))
            0:       dREN = 1;
            1:       dWEN = 1;
            default: begin dREN = 1; dWEN = 1; end
         endcase
         daddr = $urandom; dstore = $urandom;
      end
      ram_ready = (m_acc != 0) ? (int'($urandom_range(0, 99)) < p_rdy)
                               : ($urandom_range(0, 9) == 0);
      ram_load = $urandom;
   endtask

   initial begin
      RST = 1; halt = 0; iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0;
      iaddr = '0; daddr = '0; dstore = '0; ram_load = '0;
      cmp_en = 1;
      do_reset();

      // single load, RAM answers in the third strobe cycle
      dREN = 1; daddr = 32'h40; n = 0; ng = 0; done_k = 0;
      for (int k = 1; k <= 6; k++) begin
         tick();
         ram_ready = (k == 3);
         ram_load = 32'hCAFE0040;
         if (m_done_d) dREN = 0;
         #3;
         if (ram_ren) n++;
         if (ram_wen) ng++;
         if (dREN && !dwait) begin
            done_k++;
            chk("load_dload", dload, 32'hCAFE0040);
         end
      end
      chk("load_ren_cycles", n, 3);
      chk("load_wen_cycles", ng, 0);
      chk("load_dwait_low", done_k, 1);

      // data and fetch both held, one-cycle RAM: grant order D,D,D,D,I,D,...
      do_reset();
      iREN = 1; iaddr = 32'h100; dREN = 1; daddr = 32'h200; ram_ready = 1;
      ng = 0; prev = 0;
      for (int k = 0; k < 8; k++) g[k] = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (m_done_i) iREN = 0;
         ram_load = $urandom;
         #3;
         if ((ram_ren || ram_wen) && !prev && ng < 8) begin
            g[ng] = (ram_addr == 32'h100) ? 2 : 1;
            ng++;
         end
         prev = ram_ren || ram_wen;
      end
      for (int k = 0; k < 8; k++) chk($sformatf("grant_order[%0d]", k), g[k], exp_g[k]);

      // write: both strobes requested counts as a write
      do_reset();
      dREN = 1; dWEN = 1; daddr = 32'h80; dstore = 32'hDEADBEEF; ram_ready = 0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         ram_ready = (k == 2);
         if (m_done_d) begin dREN = 0; dWEN = 0; end
         #3;
         if (k <= 2) begin
            chk("wr_wen", ram_wen, 1);
            chk("wr_ren", ram_ren, 0);
            chk("wr_store", ram_store, 32'hDEADBEEF);
            chk("wr_addr", ram_addr, 32'h80);
         end
         if (k == 3) chk("wr_wen_off", ram_wen, 0);
      end

      // halt during a fetch: it finishes, later fetches starve, data still served
      do_reset();
      iREN = 1; iaddr = 32'h300;
      tick(); halt = 1; #3;
      chk("halt_fetch_strobe", ram_ren, 1);
      tick(); halt = 0; ram_ready = 1; ram_load = 32'h13579BDF; #3;
      chk("halt_fetch_iwait", iwait, 0);
      chk("halt_fetch_iload", iload, 32'h13579BDF);
      tick(); ram_ready = 0; iaddr = 32'h304;
      n = 0;
      for (int k = 0; k < 20; k++) begin
         tick(); #3;
         if (iwait && !ram_ren) n++;
      end
      chk("halt_no_fetch", n, 20);
      dREN = 1; daddr = 32'h400; n = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         ram_ready = (m_acc != 0);
         ram_load = 32'h2468ACE0;
         if (m_done_d) dREN = 0;
         #3;
         if (dREN && !dwait) begin
            n++;
            chk("halt_data_dload", dload, 32'h2468ACE0);
         end
      end
      chk("halt_data_served", n, 1);

      // timeout: RAM never answers
      do_reset();
      iREN = 0; dREN = 1; daddr = 32'h500; ram_ready = 0; done_k = -1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         ram_ready = 0;
         if (m_done_d) dREN = 0;
         #3;
         if (dREN && !dwait) begin
            done_k = k;
            chk("tmo_dload", dload, ERR_WORD);
         end
         if (k == 8) chk("tmo_err_late", ram_err, 0);
         if (k == 9) chk("tmo_err_set", ram_err, 1);
      end
      chk("tmo_cycle", done_k, 8);
      chk("tmo_err_sticky", ram_err, 1);

      // reset in the second cycle of a data access
      dREN = 1; daddr = 32'h600; n = 0;
      tick(); #3;
      chk("rstmid_err_before", ram_err, 1);
      chk("rstmid_ren_before", ram_ren, 1);
      tick(); RST = 1; ram_ready = 1; #3;
      if (!dwait) n++;
      tick(); RST = 0; ram_ready = 0; dREN = 0; #3;
      chk("rstmid_no_done", n, 0);
      chk("rstmid_ren", ram_ren, 0);
      chk("rstmid_wen", ram_wen, 0);
      chk("rstmid_err", ram_err, 0);

      // randomized traffic
      do_reset();
      for (int c = 0; c < 2000; c++) rand_cycle(40, 1);
      RST = 1; tick(); RST = 0;
      for (int c = 0; c < 2000; c++) rand_cycle(70, 0);
      for (int c = 0; c < 1000; c++) rand_cycle(10, 1);

      tick();
      cmp_en = 0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
